// File: rtl/pokemon_round_ctrl.sv
// pokemon_round_ctrl: frame-paced round controller for the green-object game.
// Picks a target box (1-9) from an on-chip LFSR, scores hits reported by the
// per-box green detector at frame refresh, and charges a life on timeout.
// Optional feature macro: POKEMON_SPEEDUP_EN (every 4th hit shrinks the
// active window by 8 frames, floor 16, restored on game start).
module pokemon_round_ctrl #(
  parameter int unsigned WINDOW_FRAMES = 120,
  parameter int unsigned GAP_FRAMES    = 30,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned SCORE_W       = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_refresh,
  input  logic [8:0]         i_box_green,
  input  logic               i_start,
  output logic [3:0]         o_target,
  output logic               o_target_valid,
  output logic               o_hit,
  output logic               o_miss,
  output logic [SCORE_W-1:0] o_score,
  output logic [2:0]         o_lives,
  output logic               o_game_over
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BOX_W  = 9;
  localparam int unsigned TGT_W  = 4;
  localparam int unsigned LIV_W  = 3;
  localparam int unsigned LFSR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_WAIT = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LFSR_W-1:0]   r_lfsr;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [TGT_W-1:0]    r_prev_target;
  logic [TGT_W-1:0]    r_target;
  logic                r_target_valid;
  logic                r_hit;
  logic                r_miss;
  logic [SCORE_W-1:0]  r_score;
  logic [LIV_W-1:0]    r_lives;
  logic                r_game_over;

  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [TGT_W-1:0]    w_prev_nxt;
  logic [TGT_W-1:0]    w_target_nxt;
  logic                w_hit_nxt;
  logic                w_miss_nxt;
  logic [SCORE_W-1:0]  w_score_nxt;
  logic [LIV_W-1:0]    w_lives_nxt;

  logic                w_lfsr_fb;
  logic [TGT_W-1:0]    w_cand_raw;
  logic [TGT_W-1:0]    w_candidate;
  logic [BOX_W-1:0]    w_tgt_mask;
  logic                w_tgt_green;
  logic                w_gap_done;
  logic                w_timeout;
  logic [CNT_W-1:0]    w_window;

`ifdef POKEMON_SPEEDUP_EN
  logic [CNT_W-1:0]    r_window;
  logic [1:0]          r_hit_mod;
  logic [CNT_W-1:0]    w_window_nxt;
  logic [1:0]          w_hit_mod_nxt;

  assign w_window = r_window;
`else
  assign w_window = CNT_W'(WINDOW_FRAMES);
`endif

  // Candidate box from the low LFSR nibble, stepped past a repeat of the last target
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand_raw  = TGT_W'(r_lfsr[3:0] % 4'd9) + 4'd1;
  assign w_candidate = (w_cand_raw != r_prev_target) ? w_cand_raw :
                       (w_cand_raw == 4'd9) ? 4'd1 : (w_cand_raw + 4'd1);

  // Only the flag of the current target box matters
  assign w_tgt_mask  = (r_target == 4'd0) ? '0 : (BOX_W'(1) << (r_target - 4'd1));
  assign w_tgt_green = |(i_box_green & w_tgt_mask);
  assign w_gap_done  = (r_frame_cnt == CNT_W'(GAP_FRAMES - 1));
  assign w_timeout   = (r_frame_cnt == (w_window - 8'd1));

  // LFSR free-runs every clock out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_frame_cnt    <= '0;
      r_prev_target  <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_miss         <= 1'b0;
      r_score        <= '0;
      r_lives        <= '0;
      r_game_over    <= 1'b0;
`ifdef POKEMON_SPEEDUP_EN
      r_window       <= CNT_W'(WINDOW_FRAMES);
      r_hit_mod      <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_frame_cnt    <= w_cnt_nxt;
      r_prev_target  <= w_prev_nxt;
      r_target       <= w_target_nxt;
      r_target_valid <= (w_state_nxt == S_WAIT);
      r_hit          <= w_hit_nxt;
      r_miss         <= w_miss_nxt;
      r_score        <= w_score_nxt;
      r_lives        <= w_lives_nxt;
      r_game_over    <= (w_state_nxt == S_OVER);
`ifdef POKEMON_SPEEDUP_EN
      r_window       <= w_window_nxt;
      r_hit_mod      <= w_hit_mod_nxt;
`endif
    end
  end

  // Next-state logic; a hit wins over a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (i_start) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (i_refresh && w_gap_done) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_refresh) begin
          if (w_tgt_green) begin
            w_state_nxt = S_GAP;
          end else if (w_timeout) begin
            w_state_nxt = (r_lives <= 3'd1) ? S_OVER : S_GAP;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for counters, target, score, lives and pulses
  always_comb begin
    w_cnt_nxt     = r_frame_cnt;
    w_prev_nxt    = r_prev_target;
    w_target_nxt  = r_target;
    w_hit_nxt     = 1'b0;
    w_miss_nxt    = 1'b0;
    w_score_nxt   = r_score;
    w_lives_nxt   = r_lives;
`ifdef POKEMON_SPEEDUP_EN
    w_window_nxt  = r_window;
    w_hit_mod_nxt = r_hit_mod;
`endif
    case (r_state)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          w_score_nxt   = '0;
          w_lives_nxt   = LIV_W'(LIVES);
          w_cnt_nxt     = '0;
          w_target_nxt  = '0;
`ifdef POKEMON_SPEEDUP_EN
          w_window_nxt  = CNT_W'(WINDOW_FRAMES);
          w_hit_mod_nxt = '0;
`endif
        end
      end
      S_GAP: begin
        if (i_refresh) begin
          if (w_gap_done) begin
            w_target_nxt = w_candidate;
            w_prev_nxt   = w_candidate;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt    = r_frame_cnt + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (i_refresh) begin
          if (w_tgt_green) begin
            w_hit_nxt    = 1'b1;
            w_score_nxt  = (&r_score) ? r_score : (r_score + SCORE_W'(1));
            w_target_nxt = '0;
            w_cnt_nxt    = '0;
`ifdef POKEMON_SPEEDUP_EN
            w_hit_mod_nxt = r_hit_mod + 2'd1;
            if (r_hit_mod == 2'd3) begin
              w_window_nxt = (r_window > 8'd24) ? (r_window - 8'd8) : 8'd16;
            end
`endif
          end else if (w_timeout) begin
            w_miss_nxt   = 1'b1;
            w_lives_nxt  = r_lives - 3'd1;
            w_target_nxt = '0;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt    = r_frame_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign o_target       = r_target;
  assign o_target_valid = r_target_valid;
  assign o_hit          = r_hit;
  assign o_miss         = r_miss;
  assign o_score        = r_score;
  assign o_lives        = r_lives;
  assign o_game_over    = r_game_over;

endmodule

// File: tb/tb_pokemon_round_ctrl.sv
// tb_pokemon_round_ctrl: randomized scoreboard bench for pokemon_round_ctrl.
// Honours POKEMON_SPEEDUP_EN in its reference model when defined.
module tb_pokemon_round_ctrl;

  localparam int WIN = 120;
  localparam int GAP = 30;
  localparam int LIV = 3;
  localparam int SW  = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int SMAX = (1 << SW) - 1;

  localparam int EV_TGT  = 1;
  localparam int EV_HIT  = 2;
  localparam int EV_MISS = 3;

  localparam int P_IDLE = 0;
  localparam int P_GAP  = 1;
  localparam int P_WAIT = 2;
  localparam int P_OVER = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_refresh = 1'b0;
  logic [8:0]    i_box_green = '0;
  logic          i_start = 1'b0;
  logic [3:0]    o_target;
  logic          o_target_valid;
  logic          o_hit;
  logic          o_miss;
  logic [SW-1:0] o_score;
  logic [2:0]    o_lives;
  logic          o_game_over;

  always #5 clk = ~clk;

  pokemon_round_ctrl #(
    .WINDOW_FRAMES(WIN), .GAP_FRAMES(GAP), .LIVES(LIV), .SCORE_W(SW), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_refresh(i_refresh), .i_box_green(i_box_green),
    .i_start(i_start), .o_target(o_target), .o_target_valid(o_target_valid),
    .o_hit(o_hit), .o_miss(o_miss), .o_score(o_score), .o_lives(o_lives),
    .o_game_over(o_game_over)
  );

  typedef struct {
    int kind;
    int target;
    int score;
    int lives;
    int over;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  bit  prev_v = 1'b0;

  // Reference model: game state advanced per driven cycle
  int          m_phase = P_IDLE;
  int          m_cnt, m_score, m_lives, m_window, m_hits, m_prev, m_target;
  logic [15:0] m_lfsr = SEED;
  int          t_fresh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic push(input int kind);
    ev_t e;
    e.kind = kind; e.target = m_target; e.score = m_score;
    e.lives = m_lives; e.over = (m_phase == P_OVER) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic model(input bit st, input bit rf, input logic [8:0] g);
    int c;
    case (m_phase)
      P_IDLE, P_OVER: if (st) begin
        m_score = 0; m_lives = LIV; m_cnt = 0; m_window = WIN; m_hits = 0;
        m_target = 0; m_phase = P_GAP;
      end
      P_GAP: if (rf) begin
        m_cnt++;
        if (m_cnt == GAP) begin
          c = (int'(m_lfsr) % 16) % 9 + 1;
          if (c == m_prev) c = (c == 9) ? 1 : c + 1;
          m_target = c; m_prev = c; m_cnt = 0; m_phase = P_WAIT;
          push(EV_TGT);
        end
      end
      P_WAIT: if (rf) begin
        if (g[m_target-1]) begin
          m_score = (m_score >= SMAX) ? SMAX : m_score + 1;
          m_hits++;
`ifdef POKEMON_SPEEDUP_EN
          if (m_hits % 4 == 0) m_window = (m_window - 8 < 16) ? 16 : m_window - 8;
`endif
          m_target = 0; m_cnt = 0; m_phase = P_GAP;
          push(EV_HIT);
        end else begin
          m_cnt++;
          if (m_cnt == m_window) begin
            m_lives--; m_target = 0; m_cnt = 0;
            m_phase = (m_lives == 0) ? P_OVER : P_GAP;
            push(EV_MISS);
          end
        end
      end
      default: ;
    endcase
  endtask

  // One clock of stimulus; the model sees the LFSR value the DUT holds at that edge
  task automatic step(input bit st, input bit rf, input logic [8:0] g);
    @(negedge clk);
    i_start = st; i_refresh = rf; i_box_green = g;
    model(st, rf, g);
    @(posedge clk);
    m_lfsr = lfsr_next(m_lfsr);
    #1;
    i_start = 1'b0; i_refresh = 1'b0; i_box_green = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_target", o_target, 0);
    chk("rst_valid", o_target_valid, 0);
    chk("rst_hit", o_hit, 0);
    chk("rst_miss", o_miss, 0);
    chk("rst_score", o_score, 0);
    chk("rst_lives", o_lives, 0);
    chk("rst_over", o_game_over, 0);
    m_phase = P_IDLE; m_cnt = 0; m_score = 0; m_lives = 0; m_window = WIN;
    m_hits = 0; m_prev = 0; m_target = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_lfsr = SEED;
    mon_en = 1'b1;
  endtask

  task automatic idle_some(input int maxn);
    int n;
    n = $urandom_range(0, maxn);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic ensure_running();
    if (m_phase == P_IDLE || m_phase == P_OVER) step(1'b1, 1'b0, '0);
  endtask

  task automatic play_gap(input int sp);
    for (int i = 0; i < 400 && m_phase == P_GAP; i++) begin
      idle_some(sp);
      step(1'($urandom_range(0, 1)), 1'b1, 9'($urandom));
    end
  endtask

  // noise: 0 none, 1 random non-target flags, 2 every non-target flag; target flag on refresh k
  task automatic play_wait(input int k, input int noise, input int sp);
    logic [8:0] tb, g;
    int r;
    r = 0;
    for (int i = 0; i < 400 && m_phase == P_WAIT; i++) begin
      r++;
      tb = 9'd1 << (m_target - 1);
      g = (noise == 0) ? 9'd0 : (noise == 1) ? (9'($urandom) & ~tb) : ~tb;
      if (r == k) g = g | tb;
      idle_some(sp);
      step(1'($urandom_range(0, 1)), 1'b1, g);
    end
  endtask

  task automatic fixed_start();
    step(1'b1, 1'b0, '0);
    repeat (GAP) begin
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a target, hit or miss
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (mon_en && rst_n) begin
      kind = o_hit ? EV_HIT : o_miss ? EV_MISS : (o_target_valid && !prev_v) ? EV_TGT : 0;
      if (kind != 0) begin
        if (q.size() == 0) begin
          chk("unexpected_event", kind, 0);
        end else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("ev_target", o_target, e.target);
          chk("ev_valid", o_target_valid, (e.kind == EV_TGT) ? 1 : 0);
          chk("ev_score", o_score, e.score);
          chk("ev_lives", o_lives, e.lives);
          chk("ev_game_over", o_game_over, e.over);
          if (kind == EV_HIT) chk("miss_with_hit", o_miss, 0);
        end
      end
      prev_v = o_target_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    do_reset();

    // Start and first target
    fixed_start();
    t_fresh = m_target;
    chk("first_target_in_range", (o_target >= 4'd1 && o_target <= 4'd9) ? 1 : 0, 1);
    chk("start_lives", o_lives, LIV);
    chk("start_score", o_score, 0);

    // Hit on the 5th refresh
    play_wait(5, 0, 2);

    // Random rounds with non-target noise and ignored starts
    repeat (6) begin
      ensure_running();
      play_gap(2);
      play_wait($urandom_range(1, 125), 1, 2);
    end

    // Tie: target flag arrives on the timeout refresh
    ensure_running();
    play_gap(1);
    play_wait(m_window, 2, 0);

    // Drive the score to saturation
    repeat (260) begin
      ensure_running();
      play_gap(0);
      play_wait(1, 0, 0);
    end

    // Timeouts until game over
    for (int i = 0; i < 12 && m_phase != P_OVER; i++) begin
      ensure_running();
      if (m_phase == P_IDLE) ensure_running();
      play_gap(0);
      play_wait(999, 0, 0);
    end
    repeat (5) step(1'b0, 1'b1, '1);
    chk("over_flag", o_game_over, 1);
    chk("over_score_held", o_score, m_score);
    chk("over_lives", o_lives, 0);
    chk("over_no_target", o_target_valid, 0);

    // Restart from game over, then reset mid-round
    step(1'b1, 1'b0, '0);
    chk("restart_score", o_score, 0);
    chk("restart_lives", o_lives, LIV);
    play_gap(1);
    repeat (3) step(1'b0, 1'b1, '0);
    do_reset();
    fixed_start();
    chk("fresh_seed_target", o_target, t_fresh);

    // Four hits, then a full timeout round
    play_wait(3, 0, 0);
    repeat (3) begin
      play_gap(0);
      play_wait(2, 0, 0);
    end
    play_gap(0);
    play_wait(999, 0, 0);

    repeat (3) step(1'b0, 1'b0, '0);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
